// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain pad enables.
// Optional device watchdog is built when PS2_HOST_TX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int TIMEOUT_CYCLES = 975000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      kclk_sync_q, kdat_sync_q;
  logic            kclk_prev_q;
  logic [9:0]      frame_q, frame_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
  logic            err_q, err_d;
  logic            kclk_s, kdat_s, fe, timeout, waiting;

  assign kclk_s  = kclk_sync_q[1];
  assign kdat_s  = kdat_sync_q[1];
  assign fe      = kclk_prev_q & ~kclk_s;
  assign waiting = (state_q == S_REQ) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Reloads on every state change and device clock edge, so it measures edge-to-edge gaps.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_d != state_q) || fe)
      to_cnt_d = TW'(TIMEOUT_CYCLES);
    else if (to_cnt_q != '0)
      to_cnt_d = to_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end

  assign timeout = waiting && (to_cnt_q == '0);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    bit_idx_d   = bit_idx_q;
    inh_cnt_d   = inh_cnt_q;
    err_d       = err_q;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          frame_d   = {~^tx_data, tx_data, 1'b0};
          bit_idx_d = 4'd0;
          inh_cnt_d = IW'(INHIBIT_CYCLES - 1);
          err_d     = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt_q == '0) begin
          bit_idx_d = 4'd0;
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q - 1'b1;
        end
      end
      S_REQ: begin
        ps2_data_oe = ~frame_q[0];
        if (timeout) begin
          ps2_data_oe = 1'b0;
          err_d       = 1'b1;
          state_d     = S_DONE;
        end else if (fe) begin
          frame_d   = {1'b1, frame_q[9:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          // The tenth edge is the stop bit: release data and await the device ACK.
          if (bit_idx_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (fe) begin
          err_d   = kdat_s;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (kclk_s && kdat_s) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_busy = (state_q != S_IDLE);
  assign tx_done = (state_q == S_DONE);
  assign tx_err  = (state_q == S_DONE) && err_q;

  // Synchronizers reset to the idle-high bus level so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kclk_sync_q <= 2'b11;
      kdat_sync_q <= 2'b11;
      kclk_prev_q <= 1'b1;
      state_q     <= S_IDLE;
      frame_q     <= '0;
      bit_idx_q   <= '0;
      inh_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      kclk_sync_q <= {kclk_sync_q[0], ps2_clk_i};
      kdat_sync_q <= {kdat_sync_q[0], ps2_data_i};
      kclk_prev_q <= kclk_s;
      state_q     <= state_d;
      frame_q     <= frame_d;
      bit_idx_q   <= bit_idx_d;
      inh_cnt_q   <= inh_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: open-drain pad model, behavioural PS/2 device, frame reference.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 10;
  localparam int TO  = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       kclk, kdat;
  int         n_tests = 0;
  int         n_fail = 0;
  int         done_cnt = 0;

  assign kclk = ~ps2_clk_oe & dev_clk;
  assign kdat = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_i(kclk), .ps2_data_i(kdat),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wire-level frame the device should see: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0), d, 1'b0};
  endfunction

  task automatic start_xfer(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    chk("accept_busy", 32'(tx_busy), 32'd1);
    chk("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
  endtask

  task automatic device(input bit nack, input int n_edges, output logic [10:0] fr);
    int cnt = 0;
    while (ps2_clk_oe && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    chk("inhibit_len", 32'(cnt), 32'(INH));
    chk("start_data_oe", 32'(ps2_data_oe), 32'd1);
    fr    = '1;
    fr[0] = kdat;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= n_edges && k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      fr[k] = kdat;
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    if (n_edges > 10) begin
      if (!nack) dev_data = 1'b0;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_data = 1'b1;
      dev_clk  = 1'b1;
    end
  endtask

  task automatic wait_done(input bit exp_err, input string tag);
    int n = 0;
    while (!tx_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(tx_done), 32'd1);
    chk({tag, "_err"}, 32'(tx_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(tx_busy), 32'd0);
  endtask

  task automatic xfer(input logic [7:0] d, input bit nack, input string tag);
    logic [10:0] fr;
    start_xfer(d);
    device(nack, 11, fr);
    chk({tag, "_frame"}, 32'(fr), 32'(ref_frame(d)));
    wait_done(nack, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [10:0] fr;
    int          d0;
    int          n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);

    // Start presented in the same cycle reset is released.
    rst = 1'b1;
    start_xfer(8'hED);
    device(1'b0, 11, fr);
    chk("led_frame", 32'(fr), 32'(ref_frame(8'hED)));
    wait_done(1'b0, "led");

    xfer(8'h07, 1'b0, "par07");
    xfer(8'h00, 1'b0, "par00");
    xfer(8'hA5, 1'b1, "nack");

    // Starts during INHIBIT and REQ must be ignored.
    start_xfer(8'hFF);
    fork
      device(1'b0, 11, fr);
      begin
        repeat (3) @(negedge clk);
        tx_data = 8'hF4; tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
        repeat (60) @(negedge clk);
        tx_data = 8'hF4; tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
      end
    join
    chk("busy_frame", 32'(fr), 32'(ref_frame(8'hFF)));
    wait_done(1'b0, "busy");
    xfer(8'hF4, 1'b0, "after_busy");

    for (int i = 0; i < 4; i++) begin
      xfer(8'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    start_xfer(8'hED);
    device(1'b0, 5, fr);
    d0 = done_cnt;
    #1 rst = 1'b0;
    #1;
    chk("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    xfer(8'hED, 1'b0, "post_rst");

`ifdef PS2_HOST_TX_TIMEOUT_EN
    start_xfer(8'h3C);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (!tx_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TO + 1));
    chk("to_err", 32'(tx_err), 32'd1);
    chk("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("to_data_oe", 32'(ps2_data_oe), 32'd0);
    @(negedge clk);
    chk("to_busy_after", 32'(tx_busy), 32'd0);
`else
    start_xfer(8'h3C);
    n = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!tx_busy) n++;
    end
    chk("hang_busy_low_cycles", 32'(n), 32'd0);
    rst = 1'b0;
    #1;
    chk("hang_rst_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the send direction of the keyboard link, sitting beside the existing PS/2 keyboard receiver on the shared `kclk`/`kdata` inout pads. It sends one command byte to the keyboard, for example 0xED set-LEDs or 0xFF reset. It runs the full host request sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, then samples the device ACK. Pad drive is open-drain: the top level drives a pad low when the matching `*_oe` output is 1 and releases it to Z otherwise.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 6500: cycles the PS2 clock is held low before the request (100 µs at 65 MHz).
- `TIMEOUT_CYCLES`, default 975000: maximum cycles allowed between device clock falling edges (15 ms).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-low reset.
- `tx_data` in, 8: command byte, sampled on accept.
- `tx_start` in, 1: request; accepted only in IDLE.
- `tx_busy` out, 1: transfer in progress.
- `tx_done` out, 1: one-cycle pulse at end of transfer (success or failure).
- `tx_err` out, 1: one-cycle pulse with `tx_done` on NACK or timeout.
- `ps2_clk_i` in, 1: PS2 clock pad input, asynchronous.
- `ps2_data_i` in, 1: PS2 data pad input, asynchronous.
- `ps2_clk_oe` out, 1: 1 drives the clock pad low.
- `ps2_data_oe` out, 1: 1 drives the data pad low.

## Operation
- Inputs pass through 2-FF synchronizers. A falling edge (`fe`) is synced clock at 1 in the previous cycle and 0 in the current cycle.
- State machine:
  - **IDLE:** when `tx_start`=1, latch `tx_data`, compute parity = ~^tx_data, go to INHIBIT.
  - **INHIBIT:** `ps2_clk_oe`=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - **REQ:** `ps2_data_oe`=1 (start bit) and `ps2_clk_oe`=0; bit index = 0. On each `fe`, present the next bit:
    - edges 1–8: data bits 0..7;
    - edge 9: parity;
    - edge 10: stop (`ps2_data_oe`=0) and go to ACK.
    - Bit value v is driven as `ps2_data_oe`=~v.
  - **ACK:** on the next `fe`, sample synced data. 0 means ACK; 1 means NACK (error flag set). Go to WAIT_IDLE.
  - **WAIT_IDLE:** wait until synced clock=1 and data=1, then go to DONE.
  - **DONE:** one cycle; pulse `tx_done` (and `tx_err` if the flag is set), then return to IDLE.
- `tx_busy`=1 in every state except IDLE.
- `tx_start` while busy is ignored, with no queueing.
- `tx_data` changes after accept have no effect.
- Reset values: `tx_busy`, `tx_done`, `tx_err`, `ps2_clk_oe`, `ps2_data_oe`, bit index, counters and error flag are all 0; state is IDLE.
- Reset mid-operation releases both pads asynchronously and the aborted byte is discarded. No `tx_done` is generated.
- `tx_start` in the cycle `rst` deasserts: a start in the first clock edge with `rst`=1 is accepted.

## Timing
- Accept to `ps2_clk_oe` rising: 1 cycle. `tx_busy` rises in the same cycle.
- `ps2_clk_oe` is high for exactly INHIBIT_CYCLES cycles. `ps2_data_oe` rises in the same cycle `ps2_clk_oe` falls.
- Pad clock fall to `ps2_data_oe` update: 3 cycles (2 sync + edge register). This is well inside the device's 5 µs minimum low half-period at any `clk` ≥ 2 MHz.
- `tx_done` and `tx_err` are asserted in the DONE cycle. `tx_busy` falls in the following cycle.
- Back-to-back: a new `tx_start` is accepted in the first IDLE cycle.
- Minimum transfer: INHIBIT_CYCLES + 11 device clock periods + WAIT_IDLE + 2 cycles.

## Configuration
- `PS2_HOST_TX_TIMEOUT_EN` defined:
  - In REQ, ACK and WAIT_IDLE, a counter restarts on every state entry and every `fe`.
  - Reaching TIMEOUT_CYCLES releases both pads in the same cycle, sets the error flag, and goes to DONE.
- Undefined: no counter is built. The block waits for the device indefinitely, and only `rst` recovers a hung transfer.

## Test plan
- **LED command:** INHIBIT_CYCLES=10, `tx_data`=0xED, bench device model clocks at a 40-cycle period and ACKs.
  - Required: `ps2_clk_oe` high exactly 10 cycles.
  - Required: device samples start 0, then bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Required: `tx_done`=1 and `tx_err`=0.
- **Parity:** `tx_data`=0x07 gives parity 0; `tx_data`=0x00 gives parity 1. Both complete with `tx_err`=0.
- **NACK:** device holds data high at the ACK edge. Required: `tx_done`=1 and `tx_err`=1 in the same cycle, then `tx_busy`=0 next cycle.
- **Busy rejection:** `tx_start` with 0xF4 while 0xFF is in flight. Required: only 0xFF is transmitted; 0xF4 is sent only after a new `tx_start` following `tx_done`.
- **Reset mid-byte:** `rst`=0 after the 5th falling edge. Required: both `*_oe`=0 and `tx_busy`=0 before the next clock edge, with no `tx_done`. A subsequent 0xED transfer completes normally.
- **Timeout:** macro defined, TIMEOUT_CYCLES=200, device never clocks.
  - Required: `tx_done`=1 and `tx_err`=1 exactly 201 cycles after REQ entry, with both pads released.
  - With the macro undefined, `tx_busy` stays 1 for 10000 cycles.
